// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera frame transmit path: the sequencer state
// encoding, default timing constants and the per-state status flags.
// -----------------------------------------------------------------------------
package cam_pkg;

    // Default timing and sizing constants.
    localparam int DEF_ADDR_W          = 15;
    localparam int DEF_BYTES_PER_FRAME = 6144;
    localparam int DEF_PRE_DELAY_CLKS  = 108500;
    localparam int DEF_GAP_CLKS        = 1085;
    localparam int DEF_RD_LAT          = 1;
    localparam int DEF_CNT_W           = 21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PRE,
        ST_FETCH,
        ST_SEND,
        ST_GAP,
        ST_POST
    } state_t;

    // Status flags that depend only on which state the sequencer is in.
    typedef struct packed {
        logic cam_en;
        logic frame_ind;
        logic busy;
    } status_t;

    // The camera may refill RAM only while waiting for a frame to begin.
    function automatic status_t state_status(input state_t st);
        status_t s;
        logic    waiting;
        waiting     = (st == ST_IDLE) || (st == ST_ARM);
        s.cam_en    = waiting;
        s.frame_ind = waiting;
        s.busy      = !waiting;
        return s;
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// -----------------------------------------------------------------------------
// vs_edge_sync
// Two-flop synchroniser for the camera vertical sync plus an edge detector on
// the synchronised value. Rise/fall are visible three clocks after the raw
// input changes.
//
// Ports:
//   Clk      in  system clock
//   i_Rst_n  in  asynchronous active-low reset
//   i_VS     in  raw vertical sync (asynchronous to Clk)
//   o_Rise   out one-clock pulse on a synchronised 0->1 transition
//   o_Fall   out one-clock pulse on a synchronised 1->0 transition
//   o_Level  out synchronised level
// -----------------------------------------------------------------------------
module vs_edge_sync (
    input  logic Clk,
    input  logic i_Rst_n,
    input  logic i_VS,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Level
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: flops are updated with non-blocking assignments so every stage
    // samples the value its predecessor held before this edge; blocking
    // assignments would collapse the chain into a single flop.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_VS;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_Rise  = r_sync & ~r_prev;
    assign o_Fall  = ~r_sync & r_prev;
    assign o_Level = r_sync;

endmodule

// File: rtl/frame_tx_sequencer.sv
// -----------------------------------------------------------------------------
// frame_tx_sequencer
// Walks a captured frame out of RAM one byte at a time into a UART
// transmitter. After a VS rise it waits PRE_DELAY_CLKS, then for each address
// waits RD_LAT for RAM data, pulses o_Tx_Start, waits for i_Tx_Done and idles
// GAP_CLKS before the next byte. Continuous mode re-arms every frame;
// single-shot mode needs an i_Start in IDLE for each frame.
//
// Ports:
//   Clk          in  system clock
//   i_Rst_n      in  asynchronous active-low reset
//   i_VS         in  camera vertical sync (asynchronous)
//   i_Mode       in  0 = continuous, 1 = single-shot
//   i_Start      in  single-shot arm pulse (only honoured in IDLE)
//   i_Tx_Done    in  transmitter byte-complete pulse (only honoured in SEND)
//   o_Tx_Start   out one-clock transmitter launch pulse
//   o_Rd_Addr    out RAM read address
//   o_Cam_En     out camera writer may fill RAM
//   o_Frame_Ind  out waiting for a frame to start
//   o_Busy       out frame transfer in progress (not IDLE/ARM)
//   o_Frame_Cnt  out completed frames, wraps at 2^16
// -----------------------------------------------------------------------------
module frame_tx_sequencer
    import cam_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
    parameter int PRE_DELAY_CLKS  = DEF_PRE_DELAY_CLKS,
    parameter int GAP_CLKS        = DEF_GAP_CLKS,
    parameter int RD_LAT          = DEF_RD_LAT,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              i_Rst_n,
    input  logic              i_VS,
    input  logic              i_Mode,
    input  logic              i_Start,
    input  logic              i_Tx_Done,
    output logic              o_Tx_Start,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    output logic              o_Cam_En,
    output logic              o_Frame_Ind,
    output logic              o_Busy,
    output logic [15:0]       o_Frame_Cnt
);

    // Terminal counts: each wait ends on the clock its counter reaches N-1.
    localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRE_DELAY_CLKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CLKS - 1);
    localparam logic [CNT_W-1:0]  FETCH_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BYTES_PER_FRAME - 1);

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_vs_level;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tx_start;
    logic [ADDR_W-1:0] r_rd_addr;
    status_t           r_status;
    logic [15:0]       r_frame_cnt;

    vs_edge_sync u_vs_edge_sync (
        .Clk     (Clk),
        .i_Rst_n (i_Rst_n),
        .i_VS    (i_VS),
        .o_Rise  (w_vs_rise),
        .o_Fall  (w_vs_fall),
        .o_Level (w_vs_level)
    );

    // Status flags only change on the ARM->PRE and POST->IDLE/ARM transitions,
    // so they are registered right alongside the state there.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tx_start  <= 1'b0;
            r_rd_addr   <= '0;
            r_status    <= state_status(ST_IDLE);
            r_frame_cnt <= '0;
        end else begin
            // Default low makes o_Tx_Start a single-clock pulse.
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!i_Mode || i_Start) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_vs_rise) begin
                        r_state  <= ST_PRE;
                        r_status <= state_status(ST_PRE);
                        r_cnt    <= '0;
                    end
                end
                ST_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_state   <= ST_FETCH;
                        r_rd_addr <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Give the RAM RD_LAT clocks to present data at the new address.
                    if (r_cnt == FETCH_LAST) begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (i_Tx_Done) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_rd_addr != LAST_ADDR) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= ST_FETCH;
                        end else begin
                            r_rd_addr   <= '0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= ST_POST;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_POST: begin
                    // Leave on the VS fall, or at once if VS is already low.
                    if (w_vs_fall || !w_vs_level) begin
                        r_state  <= i_Mode ? ST_IDLE : ST_ARM;
                        r_status <= state_status(ST_IDLE);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_status <= state_status(ST_IDLE);
                end
            endcase
        end
    end

    assign o_Tx_Start  = r_tx_start;
    assign o_Rd_Addr   = r_rd_addr;
    assign o_Cam_En    = r_status.cam_en;
    assign o_Frame_Ind = r_status.frame_ind;
    assign o_Busy      = r_status.busy;
    assign o_Frame_Cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_tx_sequencer
// Three sequencer instances share clock, reset, VS, mode and start:
//   dut0: 4 bytes/frame, RD_LAT=1
//   dut1: 1 byte/frame,  RD_LAT=3
//   dut2: 3 bytes/frame, RD_LAT=3
// all with PRE=10 and GAP=3. Each has its own transmitter model that answers
// o_Tx_Start with i_Tx_Done 20 clocks later. A frame-timeline model predicts
// every output on every clock; literal checks pin specific scenarios.
// -----------------------------------------------------------------------------
module tb_frame_tx_sequencer;

    localparam int N_DUT   = 3;
    localparam int PRE     = 10;
    localparam int GAP     = 3;
    localparam int TX_CLKS = 20;
    localparam int AW      = 15;

    typedef enum int {M_WAIT_START, M_WAIT_VS, M_XFER, M_WAIT_LOW} mphase_t;

    logic clk;
    logic rst_n;
    logic vs;
    logic mode;
    logic start;
    logic inject_spur;
    logic [N_DUT-1:0] tx_done;
    wire  [N_DUT-1:0] tx_start;
    wire  [N_DUT-1:0] cam_en;
    wire  [N_DUT-1:0] frame_ind;
    wire  [N_DUT-1:0] busy;
    wire  [AW-1:0]    addr [N_DUT];
    wire  [15:0]      fcnt [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;

    frame_tx_sequencer #(.BYTES_PER_FRAME(4), .PRE_DELAY_CLKS(PRE), .GAP_CLKS(GAP), .RD_LAT(1)) u_dut0 (
        .Clk(clk), .i_Rst_n(rst_n), .i_VS(vs), .i_Mode(mode), .i_Start(start),
        .i_Tx_Done(tx_done[0]), .o_Tx_Start(tx_start[0]), .o_Rd_Addr(addr[0]),
        .o_Cam_En(cam_en[0]), .o_Frame_Ind(frame_ind[0]), .o_Busy(busy[0]), .o_Frame_Cnt(fcnt[0]));

    frame_tx_sequencer #(.BYTES_PER_FRAME(1), .PRE_DELAY_CLKS(PRE), .GAP_CLKS(GAP), .RD_LAT(3)) u_dut1 (
        .Clk(clk), .i_Rst_n(rst_n), .i_VS(vs), .i_Mode(mode), .i_Start(start),
        .i_Tx_Done(tx_done[1]), .o_Tx_Start(tx_start[1]), .o_Rd_Addr(addr[1]),
        .o_Cam_En(cam_en[1]), .o_Frame_Ind(frame_ind[1]), .o_Busy(busy[1]), .o_Frame_Cnt(fcnt[1]));

    frame_tx_sequencer #(.BYTES_PER_FRAME(3), .PRE_DELAY_CLKS(PRE), .GAP_CLKS(GAP), .RD_LAT(3)) u_dut2 (
        .Clk(clk), .i_Rst_n(rst_n), .i_VS(vs), .i_Mode(mode), .i_Start(start),
        .i_Tx_Done(tx_done[2]), .o_Tx_Start(tx_start[2]), .o_Rd_Addr(addr[2]),
        .o_Cam_En(cam_en[2]), .o_Frame_Ind(frame_ind[2]), .o_Busy(busy[2]), .o_Frame_Cnt(fcnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bpf_of(input int id);
        case (id)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int rdl_of(input int id);
        return (id == 0) ? 1 : 3;
    endfunction

    // Clocks from one address being presented to the next: RAM latency, the
    // transmitter's 20-clock byte time, then the inter-byte gap.
    function automatic int period_of(input int id);
        return rdl_of(id) + TX_CLKS + GAP;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-timeline model ----------------
    mphase_t ph     [N_DUT] = '{M_WAIT_START, M_WAIT_START, M_WAIT_START};
    int      off    [N_DUT] = '{0, 0, 0};
    int      m_fcnt [N_DUT] = '{0, 0, 0};
    logic    v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;   // VS sampled 1, 2, 3 edges ago

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int id = 0; id < N_DUT; id++) begin
                    ph[id]     = M_WAIT_START;
                    off[id]    = 0;
                    m_fcnt[id] = 0;
                end
                v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
            end else begin
                for (int id = 0; id < N_DUT; id++) begin
                    case (ph[id])
                        M_WAIT_START: if (!mode || start) ph[id] = M_WAIT_VS;
                        M_WAIT_VS: if (v2 && !v3) begin
                            ph[id]  = M_XFER;
                            off[id] = 0;
                        end
                        M_XFER: begin
                            off[id]++;
                            if (off[id] == PRE + bpf_of(id) * period_of(id)) begin
                                ph[id]     = M_WAIT_LOW;
                                m_fcnt[id] = (m_fcnt[id] + 1) % 65536;
                            end
                        end
                        M_WAIT_LOW: if (!v2) ph[id] = mode ? M_WAIT_START : M_WAIT_VS;
                        default: ;
                    endcase
                end
                v3 = v2; v2 = v1; v1 = vs;
            end
        end
    end

    task automatic model_outs(input int id, output logic e_start, output int e_addr,
                              output logic e_wait);
        int e;
        e_start = 1'b0;
        e_addr  = 0;
        e_wait  = (ph[id] == M_WAIT_START) || (ph[id] == M_WAIT_VS);
        if (ph[id] == M_XFER && off[id] >= PRE) begin
            e       = off[id] - PRE;
            e_addr  = e / period_of(id);
            e_start = ((e % period_of(id)) == rdl_of(id));
        end
    endtask

    // ---------------- transmitter models ----------------
    int   tx_cd    [N_DUT] = '{0, 0, 0};
    logic spur_pend = 1'b0;

    initial begin : tx_model
        tx_done = '0;
        forever begin
            @(negedge clk);
            for (int id = 0; id < N_DUT; id++) begin
                tx_done[id] = (id == 0) ? spur_pend : 1'b0;
                if (id == 0) spur_pend = 1'b0;
                if (!rst_n) begin
                    tx_cd[id] = 0;
                end else begin
                    if (tx_cd[id] > 0) begin
                        tx_cd[id]--;
                        if (tx_cd[id] == 0) begin
                            tx_done[id] = 1'b1;
                            // Second done pulse lands in GAP on dut0.
                            if (id == 0 && inject_spur) spur_pend = 1'b1;
                        end
                    end
                    if (tx_start[id]) tx_cd[id] = TX_CLKS - 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int         cyc = 0;
    int         st_cnt    [N_DUT] = '{0, 0, 0};
    int         st_addr   [N_DUT][8];
    logic [AW-1:0] prev_addr [N_DUT] = '{'0, '0, '0};
    int         last_chg  [N_DUT] = '{0, 0, 0};

    initial begin : compare
        logic e_start;
        int   e_addr;
        logic e_wait;
        forever begin
            @(negedge clk);
            cyc++;
            for (int id = 0; id < N_DUT; id++) begin
                model_outs(id, e_start, e_addr, e_wait);
                check($sformatf("dut%0d tx_start", id), tx_start[id], e_start);
                check($sformatf("dut%0d rd_addr", id), addr[id], e_addr);
                check($sformatf("dut%0d cam_en", id), cam_en[id], e_wait);
                check($sformatf("dut%0d frame_ind", id), frame_ind[id], e_wait);
                check($sformatf("dut%0d busy", id), busy[id], !e_wait);
                check($sformatf("dut%0d frame_cnt", id), fcnt[id], m_fcnt[id]);
                if (addr[id] != prev_addr[id]) last_chg[id] = cyc;
                prev_addr[id] = addr[id];
                if (tx_start[id]) begin
                    if (st_cnt[id] < 8) st_addr[id][st_cnt[id]] = int'(addr[id]);
                    st_cnt[id]++;
                    if (addr[id] != '0)
                        check($sformatf("dut%0d addr-to-start latency", id), cyc - last_chg[id], rdl_of(id));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_vs(input int width);
        vs = 1'b1;
        cycles(width);
        vs = 1'b0;
    endtask

    task automatic clear_starts();
        for (int id = 0; id < N_DUT; id++) st_cnt[id] = 0;
    endtask

    task automatic expect_frame(input int id, input int n);
        check($sformatf("dut%0d start pulses", id), st_cnt[id], n);
        for (int k = 0; k < n && k < 8; k++)
            check($sformatf("dut%0d start %0d address", id, k), st_addr[id][k], k);
    endtask

    task automatic expect_all_frames();
        expect_frame(0, 4);
        expect_frame(1, 1);
        expect_frame(2, 3);
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0; vs = 1'b0; mode = 1'b0; start = 1'b0; inject_spur = 1'b0;
        cycles(3);
        check("reset tx_start", tx_start[0], 0);
        check("reset rd_addr", addr[0], 0);
        check("reset cam_en", cam_en[0], 1);
        check("reset frame_ind", frame_ind[0], 1);
        check("reset busy", busy[0], 0);
        check("reset frame_cnt", fcnt[0], 0);
        rst_n = 1'b1;
        cycles(5);

        // Continuous mode, one frame on every instance.
        clear_starts();
        pulse_vs(5);
        cycles(120);
        expect_all_frames();
        check("frame1 dut0 frame_cnt", fcnt[0], 1);
        check("frame1 dut1 frame_cnt", fcnt[1], 1);
        check("frame1 dut1 back to arm", busy[1], 0);

        // Extra VS rise during SEND and a stray Tx done in GAP.
        clear_starts();
        inject_spur = 1'b1;
        pulse_vs(5);
        cycles(13);
        pulse_vs(3);
        cycles(110);
        inject_spur = 1'b0;
        expect_all_frames();
        check("frame2 dut0 frame_cnt", fcnt[0], 2);

        // POST must hold until VS falls.
        clear_starts();
        vs = 1'b1;
        cycles(120);
        check("post hold dut0 busy", busy[0], 1);
        check("post hold dut0 frame_cnt", fcnt[0], 3);
        check("post hold dut1 busy", busy[1], 1);
        cycles(30);
        vs = 1'b0;
        cycles(10);
        check("post release dut0 busy", busy[0], 0);
        expect_all_frames();

        // Single-shot: the armed frame still runs, then the block parks in IDLE.
        mode = 1'b1;
        clear_starts();
        pulse_vs(5);
        cycles(120);
        expect_frame(0, 4);
        check("single dut0 frame_cnt", fcnt[0], 4);
        clear_starts();
        repeat (3) begin
            pulse_vs(5);
            cycles(10);
        end
        cycles(20);
        check("no start dut0 pulses", st_cnt[0], 0);
        check("no start dut2 pulses", st_cnt[2], 0);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(2);
        pulse_vs(5);
        cycles(120);
        expect_all_frames();
        check("armed dut0 frame_cnt", fcnt[0], 5);
        check("armed dut0 idle frame_ind", frame_ind[0], 1);
        clear_starts();
        pulse_vs(5);
        cycles(40);
        check("after single dut0 pulses", st_cnt[0], 0);

        // Reset in the middle of address 2 on dut0.
        mode = 1'b0;
        cycles(3);
        clear_starts();
        pulse_vs(5);
        n = 0;
        while (addr[0] != 2 && n < 200) begin
            cycles(1);
            n++;
        end
        check("reach dut0 address 2", addr[0], 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset tx_start", tx_start[0], 0);
        check("midreset rd_addr", addr[0], 0);
        check("midreset cam_en", cam_en[0], 1);
        check("midreset frame_ind", frame_ind[0], 1);
        check("midreset busy", busy[0], 0);
        check("midreset dut0 frame_cnt", fcnt[0], 0);
        check("midreset dut2 frame_cnt", fcnt[2], 0);
        cycles(3);
        rst_n = 1'b1;
        clear_starts();
        cycles(60);
        check("post reset dut0 pulses", st_cnt[0], 0);
        check("post reset dut2 pulses", st_cnt[2], 0);
        pulse_vs(5);
        cycles(120);
        expect_all_frames();
        check("post reset dut0 frame_cnt", fcnt[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_tx_sequencer.md
FRAME_TX_SEQUENCER -- requirements
Module: frame_tx_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: read-address width.
REQ-002 SHALL have parameter BYTES_PER_FRAME, default 6144: bytes sent per frame; legal range 1..2^ADDR_W.
REQ-003 SHALL have parameter PRE_DELAY_CLKS, default 108500: clocks between frame capture and first byte.
REQ-004 SHALL have parameter GAP_CLKS, default 1085: idle clocks after each Tx done before the next byte.
REQ-005 SHALL have parameter RD_LAT, default 1: RAM read latency in clocks, range 1..3.
REQ-006 SHALL have parameter CNT_W, default 21: delay-counter width; must cover max(PRE_DELAY_CLKS, GAP_CLKS).
REQ-007 SHALL have port Clk, input, 1: system clock, all logic on its rising edge.
REQ-008 SHALL have port i_Rst_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port i_VS, input, 1: camera vertical sync, asynchronous to Clk.
REQ-010 SHALL have port i_Mode, input, 1: 0 = continuous (every frame), 1 = single-shot (frame only after i_Start).
REQ-011 SHALL have port i_Start, input, 1: single-shot arm pulse, sampled only when i_Mode=1.
REQ-012 SHALL have port i_Tx_Done, input, 1: one-clock pulse from the UART transmitter when a byte has been fully sent.
REQ-013 SHALL have port o_Tx_Start, output, 1: one-clock pulse that launches the transmitter on the current RAM data.
REQ-014 SHALL have port o_Rd_Addr, output, ADDR_W: RAM read address.
REQ-015 SHALL have port o_Cam_En, output, 1: high while the camera writer may fill RAM.
REQ-016 SHALL have port o_Frame_Ind, output, 1: high while waiting for a frame to start.
REQ-017 SHALL have port o_Busy, output, 1: high in any state other than IDLE and ARM.
REQ-018 SHALL have port o_Frame_Cnt, output, 16: frames fully transmitted, wraps at 2^16.

Function
REQ-019 SHALL pass i_VS through a two-flop synchroniser; rise/fall edges are detected on the synchronised value (3-clock detection latency).
REQ-020 SHALL implement states IDLE, ARM, PRE, FETCH, SEND, GAP, POST in a single registered state machine; no split next-state/negedge update.
REQ-021 IDLE: o_Cam_En=1, o_Frame_Ind=1; goes to ARM when i_Mode=0, or when i_Mode=1 and i_Start=1.
REQ-022 ARM: o_Cam_En=1, o_Frame_Ind=1; on VS rise goes to PRE with o_Cam_En=0 and the counter cleared.
REQ-023 PRE: counts PRE_DELAY_CLKS clocks, then goes to FETCH with o_Rd_Addr=0.
REQ-024 FETCH: waits RD_LAT clocks after an address change, then issues exactly one o_Tx_Start pulse and goes to SEND.
REQ-025 SEND: holds o_Rd_Addr; on i_Tx_Done goes to GAP.
REQ-026 GAP: counts GAP_CLKS clocks. If o_Rd_Addr < BYTES_PER_FRAME-1, it increments o_Rd_Addr and goes to FETCH. Otherwise it zeroes o_Rd_Addr, increments o_Frame_Cnt, and goes to POST.
REQ-027 POST: on VS fall goes to IDLE if i_Mode=1, else to ARM. If VS is already low on entry, it goes straight through without waiting.
REQ-028 o_Tx_Start SHALL never assert outside the FETCH→SEND transition; at most one pulse per byte.
REQ-029 An i_Tx_Done arriving outside SEND SHALL be ignored.
REQ-030 VS edges outside ARM/POST SHALL be ignored; a VS rise during PRE..GAP does not restart the frame.
REQ-031 i_Start outside IDLE SHALL be ignored; i_Mode changes take effect only at the next IDLE/POST decision.
REQ-032 Counter arithmetic SHALL be CNT_W-bit unsigned; the address SHALL never exceed BYTES_PER_FRAME-1.

Reset
REQ-033 On i_Rst_n=0 the block SHALL enter IDLE immediately (asynchronously): o_Tx_Start=0, o_Rd_Addr=0, o_Cam_En=1, o_Frame_Ind=1, o_Busy=0, o_Frame_Cnt=0, counters 0, synchroniser flops 0.
REQ-034 A reset asserted mid-frame SHALL abort the transfer with no further o_Tx_Start; the partial frame SHALL NOT be counted.
REQ-035 Reset deassertion SHALL be synchronised externally; the block takes no action until the first Clk edge after release.

Structure
REQ-036 State encoding and default timing constants SHALL live in shared package cam_pkg.
REQ-037 The synchroniser plus edge detector SHALL be sub-module vs_edge_sync (outputs: rise, fall, level).
REQ-038 The RAM and the UART transmitter are external to the block; no data path passes through it.

Verification
REQ-039 Continuous mode, BYTES_PER_FRAME=4, PRE=10, GAP=3, Tx model done 20 clks after start, VS rise → 4 o_Tx_Start pulses at addresses 0,1,2,3; o_Frame_Cnt=1 after GAP; POST entered.
REQ-040 Single-shot: i_Mode=1, no i_Start, 3 VS pulses → no o_Tx_Start; then i_Start plus 1 VS → exactly one frame sent, return to IDLE.
REQ-041 Extra VS rise during SEND and a spurious i_Tx_Done in GAP → address sequence and pulse count unchanged.
REQ-042 i_Rst_n low during address 2 of a 4-byte frame → outputs at reset values the same instant, o_Frame_Cnt=0, no o_Tx_Start after release until the next VS rise.
REQ-043 RD_LAT=3 → o_Tx_Start exactly 3 clocks after each o_Rd_Addr change.
REQ-044 BYTES_PER_FRAME=1 with VS already low at POST entry → single byte sent; POST passes straight through to ARM.
